// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter: the arbiter state
// encoding and the default number of cycles to wait for a memory
// acknowledge before giving up on an access.
package mem_arb_pkg;

   // Arbiter states. The WAIT states hold a request on the memory port.
   // The DONE states present the one-cycle completion pulse to the
   // requester that owned the access.
   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_D_WAIT,
      ARB_IF_WAIT,
      ARB_D_DONE,
      ARB_IF_DONE
   } arb_state_t;

   // Default number of wait cycles without an acknowledge before an
   // access is force-completed with an error.
   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt
// Wait-cycle counter with synchronous clear, count enable and a
// terminal-count flag. The flag rises in the enabled cycle that would
// bring the number of counted cycles up to TIMEOUT.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clr    in  restart counting from zero
//   en     in  count this cycle
//   tc     out this enabled cycle is the TIMEOUT-th one
module arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // At least eight bits, wider only when TIMEOUT needs it.
   localparam int W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   // Clear has priority so a fresh access always starts from zero,
   // even if the previous one left the counter part-way through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   // Terminal count is qualified by enable so an acknowledge arriving in
   // the last allowed cycle still wins over the timeout.
   assign tc = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, variable-latency memory between the fetch
// requester (F stage) and the data requester (M stage). Data has fixed
// priority over fetch, memory-side signals are registered and held
// until acknowledged, the pipeline is stalled while an access is
// outstanding, and fetch responses squashed by a redirect are dropped.
//
// Ports:
//   clka, rst                  clock and asynchronous active-low reset
//   if_req/if_addr/if_flush    fetch request, address, redirect pulse
//   if_rdata/if_done           fetched instruction and completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb            data request (load or store)
//   d_rdata/d_done             load data and completion pulse
//   stall_f, stall_m           freeze F/D registers / whole pipeline
//   bus_err                    pulse on a timed-out completion
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb        registered memory request
//   mem_ack/mem_rdata          memory completion and read data
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   input  logic              if_flush,
   output logic [DW-1:0]     if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DW-1:0]     d_wdata,
   input  logic [DW/8-1:0]   d_wstrb,
   output logic [DW-1:0]     d_rdata,
   output logic              d_done,
   output logic              stall_f,
   output logic              stall_m,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_wstrb,
   input  logic              mem_ack,
   input  logic [DW-1:0]     mem_rdata
);

   arb_state_t    state_q, state_d;
   logic          drop;
   logic          in_wait;
   logic          cnt_en;
   logic          timed_out;
   logic          ack_eff;
   logic [DW-1:0] rdata_eff;
   logic          squash;
   logic          issue_d, issue_f;
   logic          d_fin, f_fin;

   assign in_wait = (state_q == ARB_D_WAIT) || (state_q == ARB_IF_WAIT);
   assign cnt_en  = in_wait && !mem_ack;

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clka),
      .rst_n (rst),
      .clr   (issue_d || issue_f),
      .en    (cnt_en),
      .tc    (timed_out)
   );

   // A timeout completes the access as if acknowledged with zero data.
   // A flush arriving in the very cycle of the acknowledge squashes the
   // fetch too, since the redirect already makes that instruction stale.
   assign ack_eff   = (in_wait && mem_ack) || timed_out;
   assign rdata_eff = mem_ack ? mem_rdata : '0;
   assign squash    = drop || if_flush;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and issue/finish strobes. Only IDLE may issue, so a
   // request still held high during a DONE cycle is never re-issued and
   // back-to-back accesses always have one idle cycle between them.
   always_comb begin
      state_d = state_q;
      issue_d = 1'b0;
      issue_f = 1'b0;
      d_fin   = 1'b0;
      f_fin   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (d_req) begin
               issue_d = 1'b1;
               state_d = ARB_D_WAIT;
            end else if (if_req && !if_flush) begin
               issue_f = 1'b1;
               state_d = ARB_IF_WAIT;
            end
         end
         ARB_D_WAIT: begin
            if (ack_eff) begin
               d_fin   = 1'b1;
               state_d = ARB_D_DONE;
            end
         end
         ARB_IF_WAIT: begin
            if (ack_eff) begin
               f_fin   = 1'b1;
               state_d = squash ? ARB_IDLE : ARB_IF_DONE;
            end
         end
         ARB_D_DONE, ARB_IF_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Memory-side request registers, response capture, drop flag and the
   // error pulse. The memory request fields are only loaded on issue so
   // they stay stable for the whole time mem_req is high.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         d_rdata   <= '0;
         if_rdata  <= '0;
         drop      <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= timed_out;
         drop    <= (state_q == ARB_IF_WAIT) && !ack_eff && (drop || if_flush);
         if (issue_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
         end else if (issue_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
         end else if (ack_eff) begin
            mem_req   <= 1'b0;
         end
         if (d_fin && !mem_we) begin
            d_rdata <= rdata_eff;
         end
         if (f_fin && !squash) begin
            if_rdata <= rdata_eff;
         end
      end
   end

   assign d_done  = (state_q == ARB_D_DONE);
   assign if_done = (state_q == ARB_IF_DONE);
   assign stall_m = d_req && !d_done;
   assign stall_f = (if_req && !if_done && !if_flush) || stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with TIMEOUT=4. Stimulus pushes
// the expected memory request and the expected completion into two
// queues; independent monitors pop and compare whenever the DUT raises
// mem_req or a done pulse. A small memory model answers requests after
// a programmable number of cycles.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    wstrb;
   } mem_exp_t;

   typedef struct {
      bit            is_d;
      logic [31:0]   rdata;
      logic          err;
   } resp_exp_t;

   logic              clka = 1'b0;
   logic              rst;
   logic              if_req, if_flush, d_req, d_we;
   logic [AW-1:0]     if_addr, d_addr;
   logic [DW-1:0]     d_wdata;
   logic [DW/8-1:0]   d_wstrb;
   logic [DW-1:0]     if_rdata, d_rdata;
   logic              if_done, d_done, stall_f, stall_m, bus_err;
   logic              mem_req, mem_we, mem_ack;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata, mem_rdata;
   logic [DW/8-1:0]   mem_wstrb;

   mem_exp_t          exp_mem[$];
   resp_exp_t         exp_resp[$];

   int                n_compared   = 0;
   int                n_mismatched = 0;

   bit                ack_en    = 1'b1;
   int                ack_delay = 0;
   logic [31:0]       ack_data  = '0;

   mem_port_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clka      (clka),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .stall_f   (stall_f),
      .stall_m   (stall_m),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clka = ~clka;

   // One comparison: counts it, reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Raises one request and records what the memory and the requester
   // should see for it.
   task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] exp_rdata, input bit exp_err,
                                input bit expect_resp);
      mem_exp_t  m;
      resp_exp_t r;
      if (is_d) begin
         d_req   = 1'b1;
         d_we    = we;
         d_addr  = addr;
         d_wdata = wdata;
         d_wstrb = wstrb;
         m.we = we; m.addr = addr; m.wdata = wdata; m.wstrb = wstrb;
      end else begin
         if_req  = 1'b1;
         if_addr = addr;
         m.we = 1'b0; m.addr = addr; m.wdata = '0; m.wstrb = '0;
      end
      exp_mem.push_back(m);
      if (expect_resp) begin
         r.is_d = is_d; r.rdata = exp_rdata; r.err = exp_err;
         exp_resp.push_back(r);
      end
   endtask

   task automatic nextCycle();
      @(posedge clka);
      #1;
   endtask

   // Waits (bounded) for a completion pulse, counting stall_m and mem_req
   // cycles seen before it. Returns at the falling edge of the DONE cycle.
   task automatic waitDone(input bit is_d, input string tag, output int stall_cyc, output int mreq_cyc);
      bit seen = 1'b0;
      stall_cyc = 0;
      mreq_cyc  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clka);
         if (is_d ? d_done : if_done) begin
            seen = 1'b1;
         end else begin
            if (stall_m) stall_cyc++;
            if (mem_req) mreq_cyc++;
         end
      end
      checkOutput({tag, "_done_seen"}, seen, 1'b1);
   endtask

   // Memory model: acknowledges ack_delay cycles after mem_req rises.
   initial begin
      int wcnt;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      wcnt      = 0;
      forever begin
         @(posedge clka);
         #2;
         if (!rst || !mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            wcnt      = 0;
         end else begin
            if (ack_en && wcnt == ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = ack_data;
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 32'hBAD0BAD0;
            end
            wcnt++;
         end
      end
   end

   // Memory-side monitor: every new request must match the next expected one.
   initial begin
      logic     mreq_prev;
      mem_exp_t m;
      mreq_prev = 1'b0;
      forever begin
         @(negedge clka);
         if (!rst) begin
            mreq_prev = 1'b0;
         end else begin
            if (mem_req && !mreq_prev) begin
               checkOutput("mem_req_expected", exp_mem.size() != 0, 1'b1);
               if (exp_mem.size() != 0) begin
                  m = exp_mem.pop_front();
                  checkOutput("mem_we",    mem_we,    m.we);
                  checkOutput("mem_addr",  mem_addr,  m.addr);
                  checkOutput("mem_wdata", mem_wdata, m.wdata);
                  checkOutput("mem_wstrb", mem_wstrb, m.wstrb);
               end
            end
            mreq_prev = mem_req;
         end
      end
   end

   // Requester-side monitor: every completion must match the next
   // expected response, including whether it carried a bus error.
   initial begin
      resp_exp_t r;
      forever begin
         @(negedge clka);
         if (rst) begin
            if (d_done || if_done) begin
               checkOutput("resp_expected", exp_resp.size() != 0, 1'b1);
               if (exp_resp.size() != 0) begin
                  r = exp_resp.pop_front();
                  checkOutput("resp_is_data", d_done, r.is_d);
                  checkOutput("resp_rdata", d_done ? d_rdata : if_rdata, r.rdata);
                  checkOutput("resp_bus_err", bus_err, r.err);
               end
            end else if (bus_err) begin
               checkOutput("bus_err_without_done", bus_err, 1'b0);
            end
         end
      end
   end

   // Directed test sequence.
   initial begin
      int sc, mc, dead;
      bit seen;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

      repeat (3) @(posedge clka);
      @(negedge clka);
      checkOutput("rst_mem_req",  mem_req,  1'b0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      checkOutput("rst_d_rdata",  d_rdata,  32'h0);
      checkOutput("rst_done",     {if_done, d_done, bus_err}, 3'b000);
      checkOutput("rst_stalls",   {stall_f, stall_m}, 2'b00);
      nextCycle();
      rst = 1'b1;
      nextCycle();

      $display("[TB] load with 3-cycle memory latency");
      ack_delay = 3; ack_data = 32'hDEADBEEF;
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      waitDone(1'b1, "load", sc, mc);
      checkOutput("load_stall_m_cycles", sc, 5);
      checkOutput("load_mem_req_cycles", mc, 4);
      nextCycle();
      d_req = 1'b0;
      nextCycle();

      $display("[TB] simultaneous store and fetch");
      ack_delay = 1; ack_data = 32'h00C0FFEE;
      applyStimulus(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 32'hDEADBEEF, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h00C0FFEE, 1'b0, 1'b1);
      waitDone(1'b1, "store", sc, mc);
      nextCycle();
      d_req = 1'b0;
      waitDone(1'b0, "fetch_after_store", sc, mc);
      nextCycle();
      if_req = 1'b0;
      nextCycle();

      $display("[TB] fetch squashed by flush");
      ack_delay = 3; ack_data = 32'hAAAA5555;
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clka);
      checkOutput("fetch_stall_f", stall_f, 1'b1);
      nextCycle();
      if_flush = 1'b1;
      @(negedge clka);
      checkOutput("flush_stall_f", stall_f, 1'b0);
      nextCycle();
      if_flush = 1'b0;
      if_req   = 1'b0;
      repeat (6) nextCycle();
      checkOutput("flush_if_rdata_kept", if_rdata, 32'h00C0FFEE);
      checkOutput("flush_mem_req_idle",  mem_req,  1'b0);
      ack_delay = 2; ack_data = 32'h13579BDF;
      applyStimulus(1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 32'h13579BDF, 1'b0, 1'b1);
      waitDone(1'b0, "fetch_after_flush", sc, mc);
      nextCycle();
      if_req = 1'b0;
      nextCycle();

      $display("[TB] load that times out");
      ack_en = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
      waitDone(1'b1, "timeout", sc, mc);
      checkOutput("timeout_wait_cycles", mc, 4);
      nextCycle();
      d_req = 1'b0;
      checkOutput("timeout_mem_req_idle", mem_req, 1'b0);
      ack_en = 1'b1;
      nextCycle();

      $display("[TB] asynchronous reset during a data wait");
      ack_en = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_mem_req",   mem_req,   1'b0);
      checkOutput("arst_mem_addr",  mem_addr,  32'h0);
      checkOutput("arst_mem_misc",  {mem_we, mem_wdata, mem_wstrb}, 37'h0);
      checkOutput("arst_if_rdata",  if_rdata,  32'h0);
      checkOutput("arst_d_rdata",   d_rdata,   32'h0);
      checkOutput("arst_done",      {if_done, d_done, bus_err}, 3'b000);
      d_req = 1'b0;
      nextCycle();
      rst = 1'b1; ack_en = 1'b1; ack_delay = 0; ack_data = 32'h600DF00D;
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 1'b1);
      waitDone(1'b0, "fetch_after_reset", sc, mc);
      nextCycle();
      if_req = 1'b0;
      nextCycle();

      $display("[TB] back-to-back fetch then load, zero-latency memory");
      ack_delay = 0; ack_data = 32'h11112222;
      applyStimulus(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 32'h11112222, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b1);
      waitDone(1'b0, "b2b_fetch", sc, mc);
      checkOutput("b2b_done_mem_req", mem_req, 1'b0);
      nextCycle();
      if_req = 1'b0;
      ack_data = 32'h0BADCAFE;
      dead = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clka);
         if (mem_req) seen = 1'b1;
         else dead++;
      end
      checkOutput("b2b_dead_cycles", dead, 1);
      waitDone(1'b1, "b2b_load", sc, mc);
      nextCycle();
      d_req = 1'b0;
      repeat (3) nextCycle();

      checkOutput("mem_queue_drained",  exp_mem.size(),  0);
      checkOutput("resp_queue_drained", exp_resp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-port, variable-latency memory between the pipeline's instruction-fetch requester (F stage) and data-access requester (M stage). It sits between the pipelined datapath and the unified memory. It serialises the two requesters with fixed data-over-fetch priority and holds each memory request stable until acknowledged. It produces stall signals that freeze the pipeline while an access is outstanding, and it drops fetch responses squashed by a redirect.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (`DW/8` byte strobes)
- `TIMEOUT`, 255, max cycles waiting for `mem_ack` before forced error completion (≥2)

- `clka` in 1 clock, rising edge
- `rst` in 1 asynchronous, active-low reset
- `if_req` in 1 fetch request, level, held until `if_done` or flush
- `if_addr` in AW fetch address (`pc`)
- `if_flush` in 1 redirect/flush pulse; squashes fetch in flight
- `if_rdata` out DW fetched instruction, valid while `if_done`
- `if_done` out 1 one-cycle fetch-complete pulse
- `d_req` in 1 data request, level, held until `d_done`
- `d_we` in 1 1 = store
- `d_addr` in AW data address (`alu_resultM`)
- `d_wdata` in DW store data (`writedataM`)
- `d_wstrb` in DW/8 store byte enables
- `d_rdata` out DW load data, valid while `d_done`
- `d_done` out 1 one-cycle data-complete pulse
- `stall_f` out 1 freeze F/D registers
- `stall_m` out 1 freeze entire pipeline
- `bus_err` out 1 one-cycle pulse on timeout completion
- `mem_req` out 1 memory request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out 1/AW/DW/DW/8 registered, stable while `mem_req`
- `mem_ack` in 1 one-cycle completion; `mem_rdata` valid same cycle
- `mem_rdata` in DW read data

## Operation
- States: IDLE, D_WAIT, IF_WAIT, D_DONE, IF_DONE.
- IDLE: `d_req` → latch `d_*` into `mem_*`, set `mem_req`, go to D_WAIT. Otherwise, if `if_req && !if_flush` → latch `if_addr`, `mem_we=0`, `mem_wstrb=0`, go to IF_WAIT. Otherwise stay.
- D_WAIT: on `mem_ack`, capture `mem_rdata` into `d_rdata` (loads only; stores leave it unchanged), clear `mem_req`, go to D_DONE.
- IF_WAIT: on `mem_ack`, clear `mem_req`. If `drop`=1 → IDLE with no `if_done`. Otherwise capture into `if_rdata` and go to IF_DONE.
- `drop` flag: set by `if_flush` in IF_WAIT, cleared on leaving IF_WAIT. A request is never withdrawn once issued.
- D_DONE / IF_DONE: assert the matching `*_done` for exactly this cycle, then go to IDLE. No issue takes place in a DONE cycle; this guarantees the still-high request is not re-issued.
- Timeout: an 8-bit (≥clog2 TIMEOUT) wait counter clears on entry to any WAIT state and increments each WAIT cycle without ack. On reaching TIMEOUT: treat as ack with `mem_rdata`=0 and pulse `bus_err` with the DONE/IDLE transition.
- `stall_m = d_req & ~d_done`.
- `stall_f = (if_req & ~if_done & ~if_flush) | stall_m`.
- `if_rdata` and `d_rdata` hold their last values between completions.

## Timing
- Reset (async assert, sync deassert by the clock domain): state=IDLE, `mem_req`=0, all `mem_*`=0, `if_rdata`=`d_rdata`=0, `*_done`=0, `bus_err`=0, `drop`=0, counter=0.
- Reset mid-access abandons the access; memory shares the reset.
- Minimum latency is request-seen cycle t → `mem_req` at t+1 → ack at t+1 → `*_done` at t+2. This gives 2-cycle stall minimum, plus memory wait cycles.
- Back-to-back accesses: next issue at the earliest in the IDLE cycle after DONE, so one dead cycle between accesses.
- Simultaneous `d_req` and `if_req` in IDLE: data wins, and fetch is issued after D_DONE.
- `if_flush` in IDLE with `if_req`: no issue that cycle.
- `if_flush` in IF_DONE: `if_done` still pulses; the datapath discards it via its own clear.
- `mem_ack` outside a WAIT state is ignored.

## Structure
- Shared package `mem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_D_WAIT`, `ARB_IF_WAIT`, `ARB_D_DONE`, `ARB_IF_DONE`) and the default `TIMEOUT` constant.
- One natural sub-module, `arb_timeout_cnt`: a clear/enable/terminal-count counter parameterised by `TIMEOUT`.

## Test plan
- Load only: `d_req`=1, `d_addr`=0x100, `d_we`=0; ack 3 cycles after `mem_req` with rdata 0xDEADBEEF → `d_done` one cycle, `d_rdata`=0xDEADBEEF, `stall_m` high for exactly 5 cycles.
- Simultaneous `if_req` at 0x0 and `d_req` store to 0x200 (`wdata` 0x12345678, `wstrb` 4'b0011) → memory sees the store first with those exact values; fetch is issued after D_DONE; `if_done` follows.
- Fetch to 0x40 issued, `if_flush` pulsed during wait, ack with 0xAAAA5555 → no `if_done`, `if_rdata` unchanged; next fetch to 0x80 proceeds normally.
- Memory never acks, `TIMEOUT`=4, data load → `bus_err` and `d_done` pulse together after 4 wait cycles, `d_rdata`=0, state returns to IDLE.
- `rst` asserted during D_WAIT (asynchronously, mid-cycle) → `mem_req` drops immediately, all outputs return to reset values; after release, an `if_req` issues normally.
- Ack in same cycle as `mem_req` rises, fetch then load back-to-back → exactly one dead IDLE cycle between the DONE cycle and the next `mem_req`.
